// File: rtl/decimal_entry_pkg.sv
// Shared sizes, saturation limits and FSM encoding for the decimal keypad entry path.
package decimal_entry_pkg;

  localparam int DIGITS      = 3;
  localparam int WIDTH       = 7;
  localparam int ITER        = 10;
  localparam int MAX_POS     = 63;
  localparam int MAX_NEG_MAG = 64;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FINISH
  } state_t;

endpackage

// File: rtl/bcd_to_binary_serial.sv
// Serial BCD-to-binary converter (reverse double-dabble), one shift/adjust per cycle.
// dv marks the final iteration; bin holds the result from the next cycle until the next start.
module bcd_to_binary_serial #(
  parameter int DIGITS = decimal_entry_pkg::DIGITS,
  parameter int ITER   = decimal_entry_pkg::ITER
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [ITER-1:0]       bin,
  output logic                  dv
);

  localparam int WORK_W = 4 * DIGITS + ITER;
  localparam int CNT_W  = $clog2(ITER + 1);

  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] work_next;
  logic [CNT_W-1:0]  cnt;
  logic              active;
  logic              last;

  assign shifted = work >> 1;

  // The BCD field stays in the top nibbles; any digit that received a carried-in
  // half (value >= 8) is pulled back by 3 to stay a valid decimal digit.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    work_next = shifted;
    for (int i = 0; i < DIGITS; i++) begin
      if (shifted[ITER + 4*i + 3]) begin
        work_next[ITER + 4*i +: 4] = shifted[ITER + 4*i +: 4] - 4'd3;
      end
    end
  end

  assign last = active && (cnt == CNT_W'(ITER - 1));
  assign dv   = last;
  assign bin  = work[ITER-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work   <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      work   <= {bcd, {ITER{1'b0}}};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      work   <= work_next;
      cnt    <= cnt + 1'b1;
      active <= !last;
    end
  end

endmodule

// File: rtl/decimal_entry.sv
// Keypad decimal entry buffer with sign, serial conversion and saturation to a signed WIDTH-bit value.
module decimal_entry #(
  parameter int DIGITS = decimal_entry_pkg::DIGITS,
  parameter int WIDTH  = decimal_entry_pkg::WIDTH,
  parameter int ITER   = decimal_entry_pkg::ITER
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 digit_valid,
  input  logic [3:0]           digit,
  input  logic                 neg_toggle,
  input  logic                 clear,
  input  logic                 commit,
  output logic [4*DIGITS-1:0]  entry_bcd,
  output logic                 entry_neg,
  output logic [WIDTH-1:0]     value,
  output logic                 busy,
  output logic                 done,
  output logic                 saturated
);

  import decimal_entry_pkg::*;

  state_t            state;
  state_t            next_state;
  logic              start;
  logic              sign;
  logic [ITER-1:0]   bin;
  logic              dv;
  logic [ITER-1:0]   mag_lim;
  logic [ITER-1:0]   mag_neg;
  logic              sat;
  logic [WIDTH-1:0]  result;

  bcd_to_binary_serial #(
    .DIGITS (DIGITS),
    .ITER   (ITER)
  ) u_conv (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .bcd    (entry_bcd),
    .bin    (bin),
    .dv     (dv)
  );

  always_comb begin
    next_state = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (commit && !clear) begin
          start      = 1'b1;
          next_state = CONVERT;
        end
      end
      CONVERT: if (dv) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  assign busy = (state != IDLE);

  // Edits are only honoured while idle; clear wins, and a commit swallows same-cycle edits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry_bcd <= '0;
      entry_neg <= 1'b0;
    end else if (state == IDLE) begin
      if (clear) begin
        entry_bcd <= '0;
        entry_neg <= 1'b0;
      end else if (!commit) begin
        if (digit_valid && digit <= 4'd9) entry_bcd <= {entry_bcd[4*DIGITS-5:0], digit};
        if (neg_toggle)                   entry_neg <= ~entry_neg;
      end
    end
  end

  // Negative entries may reach one further than positive ones; -0 folds to 0 through the negate.
  always_comb begin
    sat     = 1'b0;
    mag_lim = bin;
    if (!sign) begin
      if (bin > ITER'(MAX_POS)) begin
        sat     = 1'b1;
        mag_lim = ITER'(MAX_POS);
      end
    end else if (bin > ITER'(MAX_NEG_MAG)) begin
      sat     = 1'b1;
      mag_lim = ITER'(MAX_NEG_MAG);
    end
    mag_neg = ~mag_lim + 1'b1;
    result  = sign ? mag_neg[WIDTH-1:0] : mag_lim[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign      <= 1'b0;
      value     <= '0;
      saturated <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (start) sign <= entry_neg;
      done <= (state == FINISH);
      if (state == FINISH) begin
        value     <= result;
        saturated <= sat;
      end
    end
  end

endmodule

// File: tb/tb_decimal_entry.sv
// Self-checking bench for decimal_entry: decimal reference model feeding a result scoreboard.
module tb_decimal_entry;

  typedef struct packed {
    logic [6:0] v;
    logic       sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        neg_toggle = 1'b0;
  logic        clear = 1'b0;
  logic        commit = 1'b0;
  logic [11:0] entry_bcd;
  logic        entry_neg;
  logic [6:0]  value;
  logic        busy;
  logic        done;
  logic        saturated;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [11:0] exp_bcd = '0;
  logic        exp_neg = 1'b0;

  decimal_entry dut (
    .clk         (clk),
    .resetn      (resetn),
    .digit_valid (digit_valid),
    .digit       (digit),
    .neg_toggle  (neg_toggle),
    .clear       (clear),
    .commit      (commit),
    .entry_bcd   (entry_bcd),
    .entry_neg   (entry_neg),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [11:0] bcd, input logic neg);
    exp_t r;
    int   mag;
    int   v;
    mag = int'(bcd[11:8]) * 100 + int'(bcd[7:4]) * 10 + int'(bcd[3:0]);
    if (!neg) begin
      r.sat = (mag > 63);
      v     = r.sat ? 63 : mag;
    end else begin
      r.sat = (mag > 64);
      v     = r.sat ? -64 : -mag;
    end
    r.v = 7'(v);
    return r;
  endfunction

  task automatic drive(input logic dv, input logic [3:0] d, input logic nt,
                       input logic clr, input logic cm);
    digit_valid = dv;
    digit       = d;
    neg_toggle  = nt;
    clear       = clr;
    commit      = cm;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    neg_toggle  = 1'b0;
    clear       = 1'b0;
    commit      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_entry(input string tag);
    check({tag, "_bcd"}, entry_bcd, exp_bcd);
    check({tag, "_neg"}, entry_neg, exp_neg);
  endtask

  task automatic key(input logic [3:0] d, input logic nt);
    drive(1'b1, d, nt, 1'b0, 1'b0);
    if (d <= 4'd9) exp_bcd = {exp_bcd[7:0], d};
    if (nt) exp_neg = ~exp_neg;
  endtask

  task automatic toggle();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    exp_neg = ~exp_neg;
  endtask

  task automatic do_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    exp_bcd = '0;
    exp_neg = 1'b0;
  endtask

  task automatic start_commit();
    sb.push_back(model(exp_bcd, exp_neg));
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check("busy_after_commit", busy, 1'b1);
  endtask

  // n0 = clock edges already elapsed since the commit edge.
  task automatic wait_done(input string tag, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 11);
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_value"}, value, e.v);
      check({tag, "_sat"}, saturated, e.sat);
      check({tag, "_busy_low"}, busy, 1'b0);
    end
  endtask

  task automatic expect_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check({tag, "_no_done"}, seen, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_entry_bcd", entry_bcd, 12'h000);
    check("rst_entry_neg", entry_neg, 1'b0);
    check("rst_value", value, 7'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sat", saturated, 1'b0);
    resetn = 1'b1;
    idle();

    // 42
    key(4'd4, 1'b0);
    key(4'd2, 1'b0);
    check_entry("e42");
    check("e42_lit", entry_bcd, 12'h042);
    start_commit();
    wait_done("c42", 0);
    check("c42_lit", value, 7'b0101010);
    idle();
    check("c42_done_one_cycle", done, 1'b0);
    check_entry("e42_kept");

    // -5
    do_clear();
    key(4'd5, 1'b0);
    toggle();
    check_entry("em5");
    start_commit();
    wait_done("cm5", 0);
    check("cm5_lit", value, 7'b1111011);

    // 127 negative, sign toggled together with the last digit
    do_clear();
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd7, 1'b1);
    check_entry("em127");
    start_commit();
    wait_done("cm127", 0);
    check("cm127_lit", value, 7'b1000000);

    // 1234 keeps 234, invalid digit ignored, saturates positive
    do_clear();
    check_entry("clr");
    key(4'd1, 1'b0);
    key(4'd2, 1'b0);
    key(4'd3, 1'b0);
    key(4'd4, 1'b0);
    check("e234_lit", entry_bcd, 12'h234);
    key(4'hB, 1'b0);
    check_entry("e234_badkey");
    start_commit();
    // Strobes during conversion must be ignored.
    idle();
    idle();
    drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_entry("busy_ignored");
    wait_done("c234", 5);
    check("c234_lit", value, 7'd63);
    idle();

    // clear + commit: clear wins, no conversion
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    exp_bcd = '0;
    exp_neg = 1'b0;
    check("clrcm_busy", busy, 1'b0);
    check_entry("clrcm");
    expect_no_done("clrcm", 14);

    // -0 gives 0; re-commit on the done cycle
    toggle();
    check_entry("em0");
    start_commit();
    wait_done("cm0", 0);
    start_commit();
    wait_done("cm0_again", 0);

    // Reset mid-conversion
    do_clear();
    key(4'd9, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    repeat (4) idle();
    resetn = 1'b0;
    #1;
    exp_bcd = '0;
    exp_neg = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_value", value, 7'd0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_sat", saturated, 1'b0);
    check_entry("mid_rst");
    @(posedge clk); #1;
    resetn = 1'b1;
    expect_no_done("mid_rst", 14);

    key(4'd7, 1'b0);
    start_commit();
    wait_done("c7", 0);
    check("c7_lit", value, 7'd7);
    idle();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
